// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : state encoding and preset init table for regfile_sb  (rev 1.0)
// ============================================================================
package regfile_pkg;

    localparam logic [0:0] STATE_INIT = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    function automatic logic [31:0] preset_value(input int unsigned addr);
        logic [31:0] v;
        case (addr)
            32'd1:   v = 32'h11111111;
            32'd2:   v = 32'h10001000;
            32'd4:   v = 32'h00100010;
            32'd6:   v = 32'h01001000;
            32'd8:   v = 32'h11101110;
            32'd10:  v = 32'h10101010;
            32'd12:  v = 32'h01101110;
            32'd14:  v = 32'h11000110;
            32'd16:  v = 32'h10100000;
            32'd18:  v = 32'h00000fff;
            32'd20:  v = 32'h0fffffff;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// regfile_init_seq : post-reset sequencer filling the array one entry per cycle (rev 1.0)
// ============================================================================
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int INIT_PRESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [0:0]        next_state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] fill_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STATE_INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == STATE_INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (state == STATE_INIT && cnt == LAST_ADDR) begin
            next_state = STATE_RUN;
        end
    end

    generate
        if (INIT_PRESET != 0) begin : g_preset
            assign fill_value = DATA_W'(preset_value(32'(cnt)));
        end else begin : g_zero
            assign fill_value = '0;
        end
    endgenerate

    always_comb begin
        init_done = (state == STATE_RUN);
        init_we   = (state == STATE_INIT);
        init_addr = cnt;
        init_data = fill_value;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : scoreboarded register file, r0 = 0, write-to-read bypass (rev 1.0)
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NRD         = 2,
    parameter int NWR         = 2,
    parameter int INIT_PRESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    regfile_init_seq #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .INIT_PRESET (INIT_PRESET)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // Ports are applied in ascending order so the younger (higher) port wins a collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            regs[init_addr] <= init_data;
        end else if (init_done) begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && waddr[k*ADDR_W +: ADDR_W] != '0) begin
                    regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign pending[0] = 1'b0;

    generate
        for (genvar a = 1; a < DEPTH; a++) begin : g_sb
            logic wr_hit;
            logic pend_q;

            always_comb begin
                wr_hit = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(a)) begin
                        wr_hit = 1'b1;
                    end
                end
            end

            // A same-edge issue outranks the retiring write: the new producer owns the bit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pend_q <= 1'b0;
                end else if (init_done) begin
                    if (iss_en && iss_addr == ADDR_W'(a)) begin
                        pend_q <= 1'b1;
                    end else if (wr_hit) begin
                        pend_q <= 1'b0;
                    end
                end
            end

            assign pending[a] = pend_q;
        end

        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              byp_hit;
            logic [DATA_W-1:0] byp_data;
            logic [DATA_W-1:0] data;
            logic              busy;

            assign ra = raddr[i*ADDR_W +: ADDR_W];

            always_comb begin
                byp_hit  = 1'b0;
                byp_data = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && waddr[k*ADDR_W +: ADDR_W] == ra) begin
                        byp_hit  = 1'b1;
                        byp_data = wdata[k*DATA_W +: DATA_W];
                    end
                end
            end

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (rst && init_done && re[i] && ra != '0) begin
                    data = byp_hit ? byp_data : regs[ra];
                    busy = pending[ra] & ~byp_hit;
                end
            end

            assign rdata[i*DATA_W +: DATA_W] = data;
            assign rbusy[i]                  = busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded general-purpose register file for the OpenMIPS-style ID/WB stages. It has NRD read ports, NWR write ports and same-cycle write-to-read bypass, with register 0 hardwired to zero. A per-register pending bit lets ID detect operands whose producer has not yet written back. After reset, an init sequencer loads the preset test-pattern table into the array, one register per cycle, before normal operation starts.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, read ports (1..4)
- NWR, 2, write ports (1..2); higher index = younger stage
- INIT_PRESET, 1, 1: init loads preset table; 0: init loads zero
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- init_done  out  1  high once the array is initialised
- we  in  NWR  write enables
- waddr  in  NWR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- wdata  in  NWR*DATA_W  write data
- re  in  NRD  read enables
- raddr  in  NRD*ADDR_W  read addresses
- rdata  out  NRD*DATA_W  read data (combinational)
- rbusy  out  NRD  read operand still pending (combinational)
- iss_en  in  1  instruction issued with a destination register
- iss_addr  in  ADDR_W  that destination

## Operation
- States: INIT, RUN.
  - Reset: state INIT, counter 0, all pending bits 0.
  - INIT: each cycle writes the init value to regs[cnt], then cnt++. When cnt = DEPTH-1 is written, go to RUN and set init_done = 1.
  - RUN is terminal until the next reset.
- Init value:
  - INIT_PRESET=1: preset_value(cnt) from package.
  - INIT_PRESET=0: 0.
- During INIT:
  - we and iss_en are ignored.
  - rdata = 0 and rbusy = 0 on all ports.
- Write, RUN only:
  - regs[waddr[k]] <= wdata[k] when we[k] and waddr[k] != 0.
  - Two ports on the same address: the higher index wins.
- Read port i, first match wins:
  1. rst low -> 0
  2. raddr = 0 -> 0
  3. re[i] = 0 -> 0
  4. address matches an enabled write this cycle -> wdata of the highest matching port (bypass)
  5. otherwise -> regs[raddr].
- Scoreboard, RUN only, pending[0] always 0:
  - An enabled write to address a clears pending[a].
  - iss_en sets pending[iss_addr] unless iss_addr = 0.
  - Same edge, same address, issue and write: pending stays 1 (the new producer owns it).
- rbusy[i] = re[i] & (raddr != 0) & pending[raddr] & no enabled write to raddr this cycle.
- Array has no reset. Contents are defined only via INIT; reads before init_done never expose them.

## Timing
- Reset values:
  - init_done = 0.
  - rdata = 0 and rbusy = 0, forced combinationally while rst low.
  - state INIT, cnt = 0, pending = 0.
- Reset release → init_done rises after exactly DEPTH rising edges (32 for default). The first RUN write is accepted on the edge after init_done is seen high.
- Write latency: bypass visible the same cycle; array visible from the next cycle.
- Scoreboard latency: iss_en at edge t makes rbusy visible from cycle t+1.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs go to reset values immediately.
  - Pending bits clear.
  - INIT restarts from cnt = 0 after release.
- cnt is ADDR_W bits. Termination is detected on cnt = DEPTH-1, not by wrap-around.

## Structure
- Package regfile_pkg:
  - STATE_INIT / STATE_RUN encoding.
  - Function preset_value(addr), nonzero entries only, all other addresses 0:
    - r1=32'h11111111, r2=32'h10001000, r4=32'h00100010, r6=32'h01001000
    - r8=32'h11101110, r10=32'h10101010, r12=32'h01101110, r14=32'h11000110
    - r16=32'h10100000, r18=32'h00000fff, r20=32'h0fffffff
- Sub-module regfile_init_seq: state register, counter and init_done. It outputs init_we / init_addr / init_data into the array write mux.
- Read-port and scoreboard logic are generate loops in regfile_sb.

## Test plan
- Reset release, default params → init_done rises on edge 32. Then read r18 = 32'h00000fff, r20 = 32'h0fffffff, r3 = 0. With INIT_PRESET=0, r1 reads 0.
- RUN: we[0], waddr=5, wdata=32'hdeadbeef while re[1], raddr=5 → same cycle rdata1 = deadbeef. Next cycle, with we low, rdata1 still deadbeef.
- Both ports write r7, wdata0=32'h1, wdata1=32'h2 → same-cycle bypass = 2. Next cycle r7 = 2. Writing r0 with 32'hffffffff → r0 reads 0.
- iss_en, iss_addr=9 → next cycle, re[0] raddr=9: rbusy0=1.
  - Write r9 that cycle → rbusy0=0 and rdata = wdata.
  - Next cycle rbusy0=0.
  - Issue and write r9 on the same edge → rbusy0=1 afterwards.
- rst low at cycle 10 of INIT and again mid-RUN with r9 pending:
  - rdata/rbusy/init_done go 0 immediately.
  - After release, init takes a full 32 cycles.
  - r9 is not pending.
- During INIT, we to r2 and iss_en r2 → ignored. After init_done, r2 = 32'h10001000 and rbusy = 0.
